// File: rtl/sd_cmd_pkg.sv
// Shared types for the SD command arbiter: FSM state encoding, response
// status codes and command field widths.
// Contents: state_e, status_e, cmd_t, flag_status() priority decode.
package sd_cmd_pkg;

  localparam int CMD_INDEX_W = 6;
  localparam int CMD_ARG_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_RESPOND   = 3'd3,
    ST_DRAIN     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    STS_OK        = 2'b00,
    STS_INDEX_ERR = 2'b01,
    STS_TIMEOUT   = 2'b10,
    STS_WATCHDOG  = 2'b11
  } status_e;

  typedef struct packed {
    logic [CMD_INDEX_W-1:0] index;
    logic [CMD_ARG_W-1:0]   argument;
  } cmd_t;

  // Controller flag priority: complete > index_error > timeout. With no flag
  // the only way out of WAIT_DONE is the watchdog, so that is the fallback.
  function automatic status_e flag_status(input logic complete,
                                          input logic index_error,
                                          input logic timeout);
    if (complete)    return STS_OK;
    if (index_error) return STS_INDEX_ERR;
    if (timeout)     return STS_TIMEOUT;
    return STS_WATCHDOG;
  endfunction

endpackage

// File: rtl/sd_cmd_arbiter_rr.sv
// Combinational two-way round-robin pick.
// Ports: valid0_i/valid1_i requests, last_grant_i previous winner;
//        grant_valid_o any request, grant_id_o chosen requester.
module sd_rr_grant2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic grant_valid_o,
  output logic grant_id_o
);

  always_comb begin
    grant_valid_o = valid0_i | valid1_i;
    // On contention the requester that did not win last time goes next.
    if (valid0_i && valid1_i) grant_id_o = ~last_grant_i;
    else                      grant_id_o = valid1_i;
  end

endmodule

// File: rtl/sd_cmd_arbiter.sv
// Shares one SD command controller between host (req0) and DMA (req1).
// Latency: valid seen in IDLE -> ready/new_command next cycle; controller
// flag seen -> done next cycle. One command in flight; requesters hold valid
// until their ready pulse. A watchdog bounds WAIT_DONE and DRAIN.
// Ports: clock/reset; reqN_valid/index/argument in, reqN_ready/done out;
//        rsp_status/rsp_response result; new_command/cmd_index/cmd_argument
//        to the controller; ctrl_busy/response/complete/timeout/index_error in.
module sd_cmd_arbiter
  import sd_cmd_pkg::*;
#(
  parameter int WD_WIDTH        = 16,
  parameter int WATCHDOG_CYCLES = 4096
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic [CMD_INDEX_W-1:0] req0_index,
  input  logic [CMD_ARG_W-1:0]   req0_argument,
  output logic                   req0_ready,
  output logic                   req0_done,
  input  logic                   req1_valid,
  input  logic [CMD_INDEX_W-1:0] req1_index,
  input  logic [CMD_ARG_W-1:0]   req1_argument,
  output logic                   req1_ready,
  output logic                   req1_done,
  output logic [1:0]             rsp_status,
  output logic [31:0]            rsp_response,
  output logic                   new_command,
  output logic [CMD_INDEX_W-1:0] cmd_index,
  output logic [CMD_ARG_W-1:0]   cmd_argument,
  input  logic                   ctrl_busy,
  input  logic [31:0]            ctrl_response,
  input  logic                   ctrl_complete,
  input  logic                   ctrl_timeout,
  input  logic                   ctrl_index_error
);

  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(WATCHDOG_CYCLES - 1);

  state_e                 state_q, state_d;
  logic                   grant_q, grant_d;
  logic                   last_grant_q, last_grant_d;
  logic [WD_WIDTH-1:0]    wd_count_q, wd_count_d;
  logic [CMD_INDEX_W-1:0] cmd_index_q, cmd_index_d;
  logic [CMD_ARG_W-1:0]   cmd_argument_q, cmd_argument_d;
  logic                   new_command_q, new_command_d;
  logic                   req0_ready_q, req0_ready_d;
  logic                   req1_ready_q, req1_ready_d;
  logic                   req0_done_q, req0_done_d;
  logic                   req1_done_q, req1_done_d;
  status_e                rsp_status_q, rsp_status_d;
  logic [31:0]            rsp_response_q, rsp_response_d;

  logic grant_valid, grant_id;
  logic flag_any, wd_expired;
  logic [WD_WIDTH-1:0] wd_inc;
  cmd_t sel_cmd;

  sd_rr_grant2 u_rr (
    .valid0_i      (req0_valid),
    .valid1_i      (req1_valid),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  assign flag_any   = ctrl_complete | ctrl_index_error | ctrl_timeout;
  assign wd_expired = (wd_count_q == WD_LAST);
  // Saturating increment so the counter can never wrap back below WD_LAST.
  assign wd_inc     = (wd_count_q == '1) ? wd_count_q : wd_count_q + WD_WIDTH'(1);
  assign sel_cmd    = grant_id ? cmd_t'{req1_index, req1_argument}
                               : cmd_t'{req0_index, req0_argument};

  // State and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      grant_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      wd_count_q     <= '0;
      cmd_index_q    <= '0;
      cmd_argument_q <= '0;
      new_command_q  <= 1'b0;
      req0_ready_q   <= 1'b0;
      req1_ready_q   <= 1'b0;
      req0_done_q    <= 1'b0;
      req1_done_q    <= 1'b0;
      rsp_status_q   <= STS_OK;
      rsp_response_q <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      wd_count_q     <= wd_count_d;
      cmd_index_q    <= cmd_index_d;
      cmd_argument_q <= cmd_argument_d;
      new_command_q  <= new_command_d;
      req0_ready_q   <= req0_ready_d;
      req1_ready_q   <= req1_ready_d;
      req0_done_q    <= req0_done_d;
      req1_done_q    <= req1_done_d;
      rsp_status_q   <= rsp_status_d;
      rsp_response_q <= rsp_response_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (grant_valid) state_d = ST_ISSUE;
      ST_ISSUE:     state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (flag_any || wd_expired) state_d = ST_RESPOND;
      ST_RESPOND:   state_d = ST_DRAIN;
      ST_DRAIN:     if (!ctrl_busy || wd_expired) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic. Pulse outputs are decoded from the next state
  // so that they are registered yet line up with the state they belong to.
  always_comb begin
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    wd_count_d     = wd_count_q;
    cmd_index_d    = cmd_index_q;
    cmd_argument_d = cmd_argument_q;
    rsp_status_d   = rsp_status_q;
    rsp_response_d = rsp_response_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          grant_d        = grant_id;
          cmd_index_d    = sel_cmd.index;
          cmd_argument_d = sel_cmd.argument;
        end
      end
      ST_ISSUE: wd_count_d = '0;
      ST_WAIT_DONE: begin
        if (flag_any || wd_expired) begin
          rsp_status_d   = flag_status(ctrl_complete, ctrl_index_error, ctrl_timeout);
          rsp_response_d = ctrl_complete ? ctrl_response : '0;
        end else begin
          wd_count_d = wd_inc;
        end
      end
      ST_RESPOND: begin
        last_grant_d = grant_q;
        wd_count_d   = '0;
      end
      ST_DRAIN: if (ctrl_busy && !wd_expired) wd_count_d = wd_inc;
      default: ;
    endcase

    new_command_d = (state_d == ST_ISSUE);
    req0_ready_d  = new_command_d & ~grant_d;
    req1_ready_d  = new_command_d &  grant_d;
    req0_done_d   = (state_d == ST_RESPOND) & ~grant_q;
    req1_done_d   = (state_d == ST_RESPOND) &  grant_q;
  end

  assign req0_ready   = req0_ready_q;
  assign req1_ready   = req1_ready_q;
  assign req0_done    = req0_done_q;
  assign req1_done    = req1_done_q;
  assign rsp_status   = rsp_status_q;
  assign rsp_response = rsp_response_q;
  assign new_command  = new_command_q;
  assign cmd_index    = cmd_index_q;
  assign cmd_argument = cmd_argument_q;

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
`timescale 1ns/1ps
module tb_sd_cmd_arbiter;
  import sd_cmd_pkg::*;

  localparam int WDC = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [5:0]  req0_index, req1_index;
  logic [31:0] req0_argument, req1_argument;
  logic        req0_ready, req0_done, req1_ready, req1_done;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_response;
  logic        new_command;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_argument;
  logic        ctrl_busy, ctrl_complete, ctrl_timeout, ctrl_index_error;
  logic [31:0] ctrl_response;

  initial forever #5 clock = ~clock;

  sd_cmd_arbiter #(.WD_WIDTH(16), .WATCHDOG_CYCLES(WDC)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_index(req0_index), .req0_argument(req0_argument),
    .req0_ready(req0_ready), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_index(req1_index), .req1_argument(req1_argument),
    .req1_ready(req1_ready), .req1_done(req1_done),
    .rsp_status(rsp_status), .rsp_response(rsp_response),
    .new_command(new_command), .cmd_index(cmd_index), .cmd_argument(cmd_argument),
    .ctrl_busy(ctrl_busy), .ctrl_response(ctrl_response), .ctrl_complete(ctrl_complete),
    .ctrl_timeout(ctrl_timeout), .ctrl_index_error(ctrl_index_error)
  );

  typedef struct packed { logic id; logic [5:0] index; logic [31:0] arg; } exp_cmd_t;
  typedef struct packed { logic id; logic [1:0] status; logic [31:0] resp; } exp_rsp_t;
  typedef struct packed { logic [5:0] index; logic [31:0] arg; } req_t;
  typedef struct { int delay; logic c; logic ie; logic to; logic [31:0] resp; int tail; } ctrl_cfg_t;

  exp_cmd_t  exp_cmd[$];
  exp_rsp_t  exp_rsp[$];
  req_t      q0[$], q1[$];
  ctrl_cfg_t cfg_q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int nc_cnt = 0, done_cnt = 0;
  int last_nc_cyc = -100, last_done_cyc = -100;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic flag_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got unexpected event, expected none (t=%0t)", nm, $time);
  endtask

  task automatic push_cmd(input logic id, input logic [5:0] idx, input logic [31:0] arg);
    exp_cmd.push_back(exp_cmd_t'{id, idx, arg});
    if (id) q1.push_back(req_t'{idx, arg});
    else    q0.push_back(req_t'{idx, arg});
  endtask

  task automatic push_rsp(input logic id, input logic [1:0] st, input logic [31:0] resp);
    exp_rsp.push_back(exp_rsp_t'{id, st, resp});
  endtask

  task automatic push_cfg(input int delay, input logic c, input logic ie, input logic to,
                          input logic [31:0] resp, input int tail);
    ctrl_cfg_t x;
    x.delay = delay; x.c = c; x.ie = ie; x.to = to; x.resp = resp; x.tail = tail;
    cfg_q.push_back(x);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin @(posedge clock); n++; end
    check("wait_done_budget", 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic wait_nc(input int target);
    int n = 0;
    while (nc_cnt < target && n < 3000) begin @(posedge clock); n++; end
    check("wait_new_command_budget", 64'(nc_cnt >= target), 64'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req0_ready"},   64'(req0_ready),   64'd0);
    check({tag, "_req0_done"},    64'(req0_done),    64'd0);
    check({tag, "_req1_ready"},   64'(req1_ready),   64'd0);
    check({tag, "_req1_done"},    64'(req1_done),    64'd0);
    check({tag, "_rsp_status"},   64'(rsp_status),   64'd0);
    check({tag, "_rsp_response"}, 64'(rsp_response), 64'd0);
    check({tag, "_new_command"},  64'(new_command),  64'd0);
    check({tag, "_cmd_index"},    64'(cmd_index),    64'd0);
    check({tag, "_cmd_argument"}, 64'(cmd_argument), 64'd0);
  endtask

  // Requester 0: present queued commands, drop/replace valid on the edge after ready.
  initial begin : requester0
    logic seen;
    seen = 1'b0;
    req0_valid = 1'b0; req0_index = '0; req0_argument = '0;
    forever begin
      @(posedge clock); #1;
      if (req0_valid && seen) req0_valid = 1'b0;
      if (!req0_valid && q0.size() > 0) begin
        {req0_index, req0_argument} = q0.pop_front();
        req0_valid = 1'b1;
      end
      seen = req0_ready;
    end
  end

  initial begin : requester1
    logic seen;
    seen = 1'b0;
    req1_valid = 1'b0; req1_index = '0; req1_argument = '0;
    forever begin
      @(posedge clock); #1;
      if (req1_valid && seen) req1_valid = 1'b0;
      if (!req1_valid && q1.size() > 0) begin
        {req1_index, req1_argument} = q1.pop_front();
        req1_valid = 1'b1;
      end
      seen = req1_ready;
    end
  end

  // Controller model: each new_command starts the next configured transaction.
  initial begin : ctrl_model
    ctrl_cfg_t cur;
    int cnt;
    bit act;
    cnt = 0; act = 1'b0;
    cur.delay = 0; cur.c = 0; cur.ie = 0; cur.to = 0; cur.resp = '0; cur.tail = 0;
    ctrl_busy = 1'b0; ctrl_response = '0;
    ctrl_complete = 1'b0; ctrl_timeout = 1'b0; ctrl_index_error = 1'b0;
    forever begin
      @(posedge clock); #1;
      ctrl_complete = 1'b0; ctrl_timeout = 1'b0; ctrl_index_error = 1'b0;
      if (new_command && cfg_q.size() > 0) begin
        cur = cfg_q.pop_front();
        act = 1'b1; cnt = 0; ctrl_busy = 1'b1;
      end else if (act) begin
        cnt++;
        if (cnt == cur.delay) begin
          ctrl_complete = cur.c; ctrl_index_error = cur.ie; ctrl_timeout = cur.to;
          ctrl_response = cur.resp;
        end
        if (cnt >= cur.delay + cur.tail) begin act = 1'b0; ctrl_busy = 1'b0; end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin : monitor
    exp_cmd_t ec;
    exp_rsp_t er;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (new_command) begin
          nc_cnt++;
          check("grant_spacing_ge4", 64'((cyc - last_nc_cyc) >= 4), 64'd1);
          last_nc_cyc = cyc;
          if (exp_cmd.size() == 0) flag_fail("unexpected_new_command");
          else begin
            ec = exp_cmd.pop_front();
            check("ready_id", 64'({req1_ready, req0_ready}), ec.id ? 64'd2 : 64'd1);
            check("cmd_index", 64'(cmd_index), 64'(ec.index));
            check("cmd_argument", 64'(cmd_argument), 64'(ec.arg));
          end
        end else if (req0_ready || req1_ready) flag_fail("ready_without_new_command");
        if (req0_done || req1_done) begin
          done_cnt++;
          last_done_cyc = cyc;
          if (exp_rsp.size() == 0) flag_fail("unexpected_done");
          else begin
            er = exp_rsp.pop_front();
            check("done_id", 64'({req1_done, req0_done}), er.id ? 64'd2 : 64'd1);
            check("rsp_status", 64'(rsp_status), 64'(er.status));
            check("rsp_response", 64'(rsp_response), 64'(er.resp));
          end
        end
      end
    end
  end

  initial begin : main
    int base_done, base_nc;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    reset = 1'b0;
    repeat (2) @(posedge clock);

    // 1: single req0 command, complete after four cycles.
    push_cfg(4, 1, 0, 0, 32'h0000_0900, 2);
    push_cmd(0, 6'd17, 32'h0000_0200);
    push_rsp(0, STS_OK, 32'h0000_0900);
    wait_done(1);
    repeat (8) @(posedge clock);
    check("single_cmd_pulse_count", 64'(nc_cnt), 64'd1);

    // 2: both valid together right after reset -> req0 then req1.
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    push_cfg(3, 1, 0, 0, 32'h0000_0011, 3);
    push_cfg(3, 1, 0, 0, 32'h0000_0022, 1);
    push_cmd(0, 6'd5, 32'h0000_000A);
    push_cmd(1, 6'd6, 32'h0000_000B);
    push_rsp(0, STS_OK, 32'h0000_0011);
    push_rsp(1, STS_OK, 32'h0000_0022);
    wait_done(3);
    repeat (8) @(posedge clock);

    // 3: both held continuously with three commands each -> 0,1,0,1,0,1.
    for (int i = 0; i < 6; i++) push_cfg(2, 1, 0, 0, 32'h300 + 32'(i), 1);
    for (int i = 0; i < 3; i++) begin
      push_cmd(0, 6'(20 + i), 32'h1000 + 32'(i));
      push_cmd(1, 6'(30 + i), 32'h2000 + 32'(i));
    end
    for (int i = 0; i < 6; i++) push_rsp(1'(i % 2), STS_OK, 32'h300 + 32'(i));
    wait_done(9);
    repeat (8) @(posedge clock);

    // 4: index_error, then complete+timeout together.
    push_cfg(2, 0, 1, 0, 32'hDEAD_BEEF, 1);
    push_cfg(3, 1, 0, 1, 32'h1234_5678, 1);
    push_cmd(0, 6'd8, 32'h0000_0001);
    push_cmd(0, 6'd9, 32'h0000_0002);
    push_rsp(0, STS_INDEX_ERR, 32'h0);
    push_rsp(0, STS_OK, 32'h1234_5678);
    wait_done(11);
    repeat (8) @(posedge clock);

    // 5: silent controller -> watchdog; busy stuck high through DRAIN.
    base_done = done_cnt;
    base_nc   = nc_cnt;
    push_cfg(1000, 0, 0, 0, 32'hFFFF_FFFF, 0);
    push_cfg(2, 1, 0, 0, 32'h0000_0055, 1);
    push_cmd(1, 6'd40, 32'h0000_4000);
    push_cmd(1, 6'd41, 32'h0000_4100);
    push_rsp(1, STS_WATCHDOG, 32'h0);
    push_rsp(1, STS_OK, 32'h0000_0055);
    wait_done(base_done + 1);
    check("watchdog_issue_to_done", 64'(last_done_cyc - last_nc_cyc), 64'd9);
    wait_nc(base_nc + 2);
    check("drain_watchdog_done_to_issue", 64'(last_nc_cyc - last_done_cyc), 64'd10);
    wait_done(base_done + 2);
    repeat (8) @(posedge clock);

    // 6: reset during WAIT_DONE, then a normal req1 command.
    base_done = done_cnt;
    base_nc   = nc_cnt;
    push_cfg(1000, 0, 0, 0, 32'h0, 0);
    push_cmd(0, 6'd9, 32'h0000_0099);
    wait_nc(base_nc + 1);
    repeat (3) @(posedge clock);
    @(negedge clock); #2;
    reset = 1'b1;
    #1;
    check_zero("reset_in_wait");
    @(negedge clock); reset = 1'b0;
    repeat (20) @(posedge clock);
    check("no_done_after_abort", 64'(done_cnt), 64'(base_done));
    push_cfg(2, 1, 0, 0, 32'h0000_BEEF, 1);
    push_cmd(1, 6'd33, 32'h0000_CAFE);
    push_rsp(1, STS_OK, 32'h0000_BEEF);
    wait_done(base_done + 1);
    repeat (8) @(posedge clock);

    check("exp_cmd_left", 64'(exp_cmd.size()), 64'd0);
    check("exp_rsp_left", 64'(exp_rsp.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
